uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one user UART transmitter between several byte producers (e.g. CPU console path, debug/ISP path) so their output is not interleaved mid-line. Grants the UART to one requester at a time with round-robin fairness and line-level locking, then writes that requester's bytes to the UART TX slave over a naive_bus master port with wr_gnt backpressure. Sits between the producers and the UART TX slave's FIFO at address 0.

## Interface
- NREQ, 2: number of requesters (2..4)
- MAX_BURST, 256: max bytes per grant before forced release (1..65535)
- IDLE_TIMEOUT, 1024: owner-idle cycles before forced release (1..65535)
- EOL_CHAR, 8'h0A: byte whose acceptance ends a grant
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_ready  out  NREQ  per-requester accept; byte transfers on valid & ready
- owner_id  out  2  index of current/last owner
- busy  out  1  high in OWN or while hold register is full
- bus  naive_bus.master  write-only master to the UART TX slave

## Operation
- States: IDLE, OWN. Registers: state, owner, last_owner, hold_data[7:0], hold_valid, burst_cnt[15:0], idle_cnt[15:0].
- IDLE: if any req_valid, owner <= first i with req_valid[i], scanning last_owner+1, +2, ... modulo NREQ; burst_cnt, idle_cnt <= 0; go OWN. Otherwise stay.
- OWN: req_ready[owner] = ~hold_valid; all other req_ready = 0. In IDLE all req_ready = 0.
- Accept (OWN, req_valid[owner] & ~hold_valid): hold_data <= byte, hold_valid <= 1, burst_cnt += 1, idle_cnt <= 0.
- OWN with no accept: idle_cnt += 1 (saturating).
- Release to IDLE, last_owner <= owner, when any of: accepted byte == EOL_CHAR; accept with burst_cnt+1 == MAX_BURST; idle_cnt+1 == IDLE_TIMEOUT with no accept that cycle. Released byte still drains from hold.
- Bus write: wr_req = hold_valid; wr_addr = 32'h0; wr_be = 4'b0001; wr_data = {24'h0, hold_data}. hold_valid clears on the wr_req & wr_gnt cycle.
- Read side unused: rd_req = 0, rd_addr = 0.
- Hold never accepts a new byte while full, so a new owner's first byte waits until the previous owner's last byte is granted.

## Timing
- Reset (async, rst=1): state=IDLE, owner=0, last_owner=NREQ-1 (so requester 0 is first after reset), hold_valid=0, counters=0; req_ready=0, wr_req=0, busy=0, owner_id=0. Reset mid-transfer drops the held byte; no partial bus write.
- IDLE -> OWN: 1 cycle after a req_valid is seen; req_ready[owner] high in first OWN cycle.
- Byte accepted at cycle N -> wr_req high at N+1; if wr_gnt at N+1, hold clears and next accept possible at N+2. Peak throughput 1 byte / 2 cycles.
- wr_gnt low (slave FIFO full): wr_req, wr_data held stable until granted; req_ready stays low.
- Simultaneous accept and gnt in the same cycle cannot occur (accept requires hold empty).
- Release then immediate new grant: OWN->IDLE->OWN takes 2 cycles minimum.
- Counters saturate, never wrap.

## Test plan
- Reset: assert rst mid-stream with hold_valid=1 -> wr_req=0, req_ready=0, busy=0 same cycle; after release requester 0 wins first when 0 and 1 both valid.
- Line locking: req 0 sends "AB\n", req 1 sends "xy\n" concurrently -> bus write order 41,42,0A,78,79,0A; owner_id 0 then 1.
- Round-robin: both requesters continuously valid, lines of 1 byte (0x0A) -> grants alternate 0,1,0,1.
- Backpressure: hold wr_gnt=0 for 50 cycles with byte 0x55 held -> wr_data stays 0x55, wr_req stays 1, req_ready=0; one write of 0x55 after gnt.
- Burst limit: MAX_BURST=4, req 0 streams 10 non-EOL bytes, req 1 valid -> req 0 releases after 4 bytes, req 1 granted next.
- Idle timeout: IDLE_TIMEOUT=8, req 0 sends 1 byte then drops valid -> release to IDLE 8 cycles later; req 1 then granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// naive_bus: simple request/grant memory-style bus with independent read and
// write channels. A transfer happens on any cycle where req and gnt are both high.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: lets several byte producers share one UART TX slave.
// One requester owns the UART at a time (round-robin choice), and keeps it
// until it sends an end-of-line byte, hits the burst limit, or goes idle.
// Accepted bytes pass through a one-byte hold register that is written to
// the slave FIFO at address 0 with wr_gnt backpressure.
module uart_tx_arbiter #(
  parameter int          NREQ         = 2,
  parameter int          MAX_BURST    = 256,
  parameter int          IDLE_TIMEOUT = 1024,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [1:0]        owner_id,
  output logic              busy,
  naive_bus.master          bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  owner;
  logic [1:0]  last_owner;
  logic [7:0]  hold_data;
  logic        hold_valid;
  logic [15:0] burst_cnt;
  logic [15:0] idle_cnt;

  logic [1:0]  pick;
  logic        any_valid;
  logic        owner_valid;
  logic [7:0]  owner_byte;
  logic        accept;
  logic        wr_fire;
  logic        eol_hit;
  logic        burst_hit;
  logic        idle_hit;
  logic        release_own;
  logic [16:0] burst_inc;
  logic [16:0] idle_inc;

  assign any_valid = |req_valid;
  assign accept    = (state == OWN) && owner_valid && !hold_valid;
  assign wr_fire   = hold_valid && bus.wr_gnt;
  assign burst_inc = {1'b0, burst_cnt} + 17'd1;
  assign idle_inc  = {1'b0, idle_cnt} + 17'd1;

  assign eol_hit     = accept && (owner_byte == EOL_CHAR);
  assign burst_hit   = accept && (burst_inc == 17'(MAX_BURST));
  assign idle_hit    = (state == OWN) && !accept && (idle_inc == 17'(IDLE_TIMEOUT));
  assign release_own = eol_hit || burst_hit || idle_hit;

  // Round-robin pick: first valid requester after last_owner, wrapping around.
  always_comb begin
    logic found;
    int   idx;
    pick  = last_owner;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
  end

  // Select the current owner's valid and data lanes.
  always_comb begin
    owner_valid = 1'b0;
    owner_byte  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 2'(i)) begin
        owner_valid = req_valid[i];
        owner_byte  = req_data[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-requester ready; only the owner is ready, and only with the hold empty.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = OWN;
        end
      end
      OWN: begin
        for (int i = 0; i < NREQ; i++) begin
          if (owner == 2'(i)) begin
            req_ready[i] = !hold_valid;
          end
        end
        if (release_own) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership bookkeeping and the saturating burst / idle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 2'd0;
      last_owner <= 2'(NREQ - 1);
      burst_cnt  <= 16'd0;
      idle_cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner     <= pick;
            burst_cnt <= 16'd0;
            idle_cnt  <= 16'd0;
          end
        end
        OWN: begin
          if (accept) begin
            if (burst_cnt != 16'hFFFF) begin
              burst_cnt <= burst_inc[15:0];
            end
            idle_cnt <= 16'd0;
          end else if (idle_cnt != 16'hFFFF) begin
            idle_cnt <= idle_inc[15:0];
          end
          if (release_own) begin
            last_owner <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  // One-byte hold register: filled on accept, emptied when the slave grants the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= owner_byte;
    end else if (wr_fire) begin
      hold_valid <= 1'b0;
    end
  end

  assign owner_id = owner;
  assign busy     = (state == OWN) || hold_valid;

  assign bus.wr_req  = hold_valid;
  assign bus.wr_addr = 32'h0;
  assign bus.wr_be   = 4'b0001;
  assign bus.wr_data = {24'h0, hold_data};
  assign bus.rd_req  = 1'b0;
  assign bus.rd_addr = 32'h0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: two producers driven from byte queues, a
// scoreboard of expected bus bytes and expected grant order.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  owner_id;
  logic        busy;

  naive_bus bus ();

  uart_tx_arbiter #(
    .NREQ         (2),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (8),
    .EOL_CHAR     (8'h0A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .owner_id  (owner_id),
    .busy      (busy),
    .bus       (bus.master)
  );

  int tests    = 0;
  int failures = 0;

  logic [7:0] src_q0[$];
  logic [7:0] src_q1[$];
  logic [7:0] exp_bytes[$];
  int         exp_src[$];
  logic [1:0] en;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue bytes for a producer and record the bytes the bus should carry.
  task automatic applyStimulus(input int src, input logic [7:0] b, input bit expect_write);
    if (src == 0) src_q0.push_back(b);
    else          src_q1.push_back(b);
    if (expect_write) exp_bytes.push_back(b);
  endtask

  task automatic expectGrant(input int src, input int n);
    for (int k = 0; k < n; k++) exp_src.push_back(src);
  endtask

  task automatic waitDrain(input string tag);
    int c;
    c = 0;
    while ((exp_bytes.size() != 0 || exp_src.size() != 0 ||
            src_q0.size() != 0 || src_q1.size() != 0 || busy) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, "_drain_left"}, 32'(exp_bytes.size() + exp_src.size()), 32'd0);
  endtask

  task automatic stepCycles(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #2;
  endtask

  // Producer driver and bus monitor: sample at negedge, update after posedge.
  initial begin : driver
    logic [1:0] xfer;
    logic       fire;
    int         e;
    logic [7:0] eb;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    forever begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      fire = bus.wr_req && bus.wr_gnt && !rst;
      for (int i = 0; i < 2; i++) begin
        if (xfer[i]) begin
          if (exp_src.size() == 0) begin
            checkOutput("extra_grant", 32'(exp_src.size()), 32'd1);
          end else begin
            e = exp_src.pop_front();
            checkOutput("grant_src", 32'(i), 32'(e));
            checkOutput("owner_id", {30'd0, owner_id}, 32'(e));
          end
        end
      end
      if (fire) begin
        if (exp_bytes.size() == 0) begin
          checkOutput("extra_write", 32'(exp_bytes.size()), 32'd1);
        end else begin
          eb = exp_bytes.pop_front();
          checkOutput("wr_data", bus.wr_data, {24'h0, eb});
          checkOutput("wr_addr", bus.wr_addr, 32'h0);
          checkOutput("wr_be", {28'd0, bus.wr_be}, 32'h1);
        end
      end
      @(posedge clk);
      #1;
      if (xfer[0] && src_q0.size() != 0) void'(src_q0.pop_front());
      if (xfer[1] && src_q1.size() != 0) void'(src_q1.pop_front());
      req_valid[0]   = en[0] && (src_q0.size() != 0);
      req_data[7:0]  = (src_q0.size() != 0) ? src_q0[0] : 8'h00;
      req_valid[1]   = en[1] && (src_q1.size() != 0);
      req_data[15:8] = (src_q1.size() != 0) ? src_q1[0] : 8'h00;
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int c;
    en             = 2'b11;
    bus.wr_gnt     = 1'b1;
    bus.rd_gnt     = 1'b0;
    bus.rd_data    = 32'h0;
    rst            = 1'b1;
    stepCycles(3);

    // Reset values.
    checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_owner_id", {30'd0, owner_id}, 32'd0);
    checkOutput("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    @(negedge clk);
    #3 rst = 1'b0;
    stepCycles(2);

    // Line locking: both start together, requester 0 finishes its line first.
    applyStimulus(0, 8'h41, 1); applyStimulus(0, 8'h42, 1); applyStimulus(0, 8'h0A, 1);
    applyStimulus(1, 8'h78, 1); applyStimulus(1, 8'h79, 1); applyStimulus(1, 8'h0A, 1);
    expectGrant(0, 3);
    expectGrant(1, 3);
    waitDrain("linelock");

    // Round-robin with one-byte lines.
    stepCycles(1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 8'h0A, 1);
      applyStimulus(1, 8'h0A, 1);
    end
    for (int k = 0; k < 3; k++) begin
      expectGrant(0, 1);
      expectGrant(1, 1);
    end
    waitDrain("roundrobin");

    // Backpressure: byte 0x55 held while the slave refuses writes.
    stepCycles(1);
    bus.wr_gnt = 1'b0;
    applyStimulus(0, 8'h55, 1);
    expectGrant(0, 1);
    c = 0;
    @(negedge clk);
    while (!bus.wr_req && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput("bp_hold_full", {31'd0, bus.wr_req}, 32'd1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checkOutput("bp_wr_req", {31'd0, bus.wr_req}, 32'd1);
      checkOutput("bp_wr_data", bus.wr_data, 32'h55);
      checkOutput("bp_req_ready", {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #2 bus.wr_gnt = 1'b1;
    waitDrain("backpressure");

    // Burst limit of 4: requester 0 streams, requester 1 joins once 0 owns the UART.
    stepCycles(1);
    en = 2'b01;
    for (int k = 0; k < 10; k++) applyStimulus(0, 8'(8'h10 + k), 0);
    applyStimulus(1, 8'h20, 0);
    applyStimulus(1, 8'h0A, 0);
    for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(8'h10 + k));
    exp_bytes.push_back(8'h20);
    exp_bytes.push_back(8'h0A);
    for (int k = 4; k < 10; k++) exp_bytes.push_back(8'(8'h10 + k));
    expectGrant(0, 4);
    expectGrant(1, 2);
    expectGrant(0, 6);
    stepCycles(4);
    en = 2'b11;
    waitDrain("burst");

    // Idle timeout: one byte from requester 0, then silence.
    stepCycles(1);
    en = 2'b01;
    applyStimulus(0, 8'h31, 1);
    expectGrant(0, 1);
    c = 0;
    @(negedge clk);
    while (!(req_valid[0] && req_ready[0]) && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput("idle_accept_seen", {31'd0, req_ready[0]}, 32'd1);
    c = 0;
    @(negedge clk);
    while (busy && c < 100) begin
      c++;
      @(negedge clk);
    end
    checkOutput("idle_busy_cycles", 32'(c), 32'd8);
    applyStimulus(1, 8'h41, 1);
    applyStimulus(1, 8'h0A, 1);
    expectGrant(1, 2);
    en = 2'b11;
    waitDrain("idle");

    // Reset with a byte stuck in the hold register.
    stepCycles(1);
    bus.wr_gnt = 1'b0;
    applyStimulus(0, 8'h99, 0);
    expectGrant(0, 1);
    c = 0;
    @(negedge clk);
    while (!bus.wr_req && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput("mid_hold_full", {31'd0, bus.wr_req}, 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid_rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
    checkOutput("mid_rst_req_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_owner", {30'd0, owner_id}, 32'd0);
    bus.wr_gnt = 1'b1;
    stepCycles(2);
    @(negedge clk);
    #3 rst = 1'b0;
    stepCycles(2);
    applyStimulus(0, 8'hA1, 1); applyStimulus(0, 8'h0A, 1);
    applyStimulus(1, 8'hB1, 1); applyStimulus(1, 8'h0A, 1);
    expectGrant(0, 2);
    expectGrant(1, 2);
    waitDrain("after_reset");

    stepCycles(3);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
